// File: rtl/aes_inv_cipher_pkg.sv
// Shared AES decryption helpers: inverse S-box, inverse round transforms and round count lookup.
// Blocks are column-major, with byte 0 in bits [127:120].
package aes_inv_cipher_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'b00,
        KEY_192 = 2'b10,
        KEY_256 = 2'b11
    } key_len_t;

    typedef logic [0:15][7:0] aes_block_t;

    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry 0 sits in the top byte of the table.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant built from doublings.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

    function automatic logic [3:0] num_rounds(input logic [1:0] kl);
        case (kl)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        aes_block_t b;
        b = s;
        for (int i = 0; i < 16; i++) begin
            b[i] = inv_sbox(b[i]);
        end
        return b;
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        aes_block_t b;
        b = s;
        return {b[0],  b[13], b[10], b[7],
                b[4],  b[1],  b[14], b[11],
                b[8],  b[5],  b[2],  b[15],
                b[12], b[9],  b[6],  b[3]};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul_const(a0, 4'he) ^ gf_mul_const(a1, 4'hb) ^ gf_mul_const(a2, 4'hd) ^ gf_mul_const(a3, 4'h9),
                gf_mul_const(a0, 4'h9) ^ gf_mul_const(a1, 4'he) ^ gf_mul_const(a2, 4'hb) ^ gf_mul_const(a3, 4'hd),
                gf_mul_const(a0, 4'hd) ^ gf_mul_const(a1, 4'h9) ^ gf_mul_const(a2, 4'he) ^ gf_mul_const(a3, 4'hb),
                gf_mul_const(a0, 4'hb) ^ gf_mul_const(a1, 4'hd) ^ gf_mul_const(a2, 4'h9) ^ gf_mul_const(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
                inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round; the final round omits InvMixColumns.
module aes_inv_round
    import aes_inv_cipher_pkg::*;
(
    input  logic [127:0] in,
    input  logic [127:0] rk,
    input  logic         final_round,
    output logic [127:0] out
);

    logic [127:0] shifted;
    logic [127:0] substituted;
    logic [127:0] keyed;
    logic [127:0] mixed;

    assign shifted     = inv_shift_rows(in);
    assign substituted = inv_sub_bytes(shifted);
    assign keyed       = substituted ^ rk;
    assign mixed       = inv_mix_columns(keyed);
    assign out         = final_round ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128/192/256 decryption core, one round per clock, walking round keys from Nr down to 0.
module aes_inv_cipher
    import aes_inv_cipher_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic         ready,
    input  logic         key_valid,
    input  logic [1:0]   key_length,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         aborted
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    fsm_t         fsm_reg;
    logic [3:0]   cnt_reg;
    logic [3:0]   nr_reg;
    logic [127:0] state_reg;
    logic [127:0] data_out_reg;
    logic         out_valid_reg;
    logic         aborted_reg;

    logic [3:0]   nr_sel;
    logic [127:0] round_out;

    assign nr_sel = num_rounds(key_length);

    aes_inv_round u_round (
        .in          (state_reg),
        .rk          (round_key),
        .final_round (cnt_reg == 4'd0),
        .out         (round_out)
    );

    always_comb begin
        round = 4'd0;
        case (fsm_reg)
            IDLE:    round = nr_sel;
            ROUND:   round = cnt_reg;
            default: round = 4'd0;
        endcase
    end

    assign ready     = (fsm_reg == IDLE) && key_valid;
    assign data_out  = data_out_reg;
    assign out_valid = out_valid_reg;
    assign aborted   = aborted_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg       <= IDLE;
            cnt_reg       <= 4'd0;
            nr_reg        <= 4'd10;
            state_reg     <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            aborted_reg <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (start && ready) begin
                        state_reg <= data_in ^ round_key;
                        nr_reg    <= nr_sel;
                        cnt_reg   <= nr_sel - 4'd1;
                        fsm_reg   <= ROUND;
                    end
                end
                ROUND: begin
                    // A counter outside the latched round range can only come from an upset; drop it like a key loss.
                    if (!key_valid || (cnt_reg >= nr_reg)) begin
                        aborted_reg <= 1'b1;
                        fsm_reg     <= IDLE;
                    end else if (cnt_reg == 4'd0) begin
                        data_out_reg  <= round_out;
                        out_valid_reg <= 1'b1;
                        fsm_reg       <= DONE;
                    end else begin
                        state_reg <= round_out;
                        cnt_reg   <= cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        fsm_reg       <= IDLE;
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end

endmodule
